sdrc_req_queue: RTL and testbench
=================================

SDRC_REQ_QUEUE -- requirements
Module: sdrc_req_queue

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  APP_RW   9  request length width
  ID_W     4  request ID width
  DEPTH    4  queue entries, power of two, minimum 2
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk          in   1       single clock, rising edge
  reset        in   1       synchronous, active-high
  r2b_req      in   1       chunk request from request generator
  r2b_req_id   in   ID_W    request ID
  r2b_start    in   1       first chunk of burst
  r2b_last     in   1       last chunk of burst
  r2b_wrap     in   1       wrap mode
  r2b_write    in   1       1 = write
  r2b_ba       in   2       bank
  r2b_raddr    in   12      row
  r2b_caddr    in   12      column
  r2b_len      in   APP_RW  chunk length
  b2r_ack      out  1       chunk accepted this cycle
  b2r_arb_ok   out  1       room for a new application request
  q_valid      out  1       head entry valid
  q_req_id, q_start, q_last, q_wrap, q_write, q_ba, q_raddr, q_caddr, q_len  out  (widths as inputs)  head entry fields
  q_row_hit    out  1       head row already open in its bank
  q_pop        in   1       consumer takes head entry
  bank_close   in   4       per-bank precharge done; one bit per bank
  q_count      out  clog2(DEPTH)+1  occupancy
REQ-003 Clock and reset SHALL be one clock, clk; reset synchronous, active-high, named reset.

Function
REQ-004 Storage SHALL be a circular FIFO of DEPTH entries holding all r2b_* fields except r2b_req.
REQ-005 b2r_ack SHALL be combinational: r2b_req & (q_count != DEPTH).
REQ-006 When b2r_ack is high, the block SHALL write the inputs at the tail and advance the write pointer at the next edge.
REQ-007 A push into an empty queue SHALL make q_valid high on the next cycle, with no same-cycle bypass.
REQ-008 q_valid SHALL equal (q_count != 0); q_* field outputs SHALL reflect the head entry combinationally from storage.
REQ-009 q_pop with q_valid high SHALL advance the read pointer; q_pop with q_valid low SHALL be ignored, with no pointer or count change.
REQ-010 Simultaneous push and pop SHALL leave q_count unchanged.
REQ-011 When full, a push SHALL NOT be accepted even if q_pop is high in the same cycle.
REQ-012 Pointers SHALL wrap modulo DEPTH.
REQ-013 q_count SHALL be 0..DEPTH and SHALL never overflow or underflow.
REQ-014 b2r_arb_ok SHALL be combinational: q_count <= DEPTH-2, so that a page-split request always fits two chunks.
REQ-015 Open-row table per bank: open_valid[3:0] and open_row[ba][11:0].
REQ-016 On an accepted pop, open_valid[q_ba] SHALL be set to 1 and open_row[q_ba] set to q_raddr.
REQ-017 bank_close[i] SHALL clear open_valid[i].
REQ-018 If a pop and bank_close hit the same bank in the same cycle, the pop SHALL win.
REQ-019 q_row_hit SHALL be q_valid & open_valid[q_ba] & (open_row[q_ba] == q_raddr); it SHALL be 0 when empty.
REQ-020 The block SHALL NOT reorder entries; order SHALL be strict FIFO.

Reset
REQ-021 While reset is high at a clock edge, the following SHALL be cleared: pointers, q_count=0, open_valid=0.
REQ-022 During and after reset: q_valid=0, q_row_hit=0, b2r_arb_ok=1, b2r_ack = r2b_req.
REQ-023 Storage data and open_row SHALL be left unreset.
REQ-024 A reset asserted mid-operation SHALL discard all queued entries within one edge; r2b_req present in that cycle SHALL NOT be stored.

Verification
REQ-025 Single push: push ba=2, raddr=0x055, caddr=0x0F0, len=8, id=3 -> next cycle q_valid=1 with matching fields, q_row_hit=0, q_count=1.
REQ-026 Fill/full: DEPTH=4, 4 pushes, no pop -> b2r_arb_ok low once q_count=3; b2r_ack=0 with q_count=4; push plus pop while full -> q_count stays 4 and the pushed data is not stored.
REQ-027 Row tracking: pop entry ba=1 row=0x100; next head ba=1 row=0x100 -> q_row_hit=1; pulse bank_close=4'b0010 -> q_row_hit=0; pop together with bank_close[1] -> open_valid[1] stays 1.
REQ-028 Wrap-around: 10 interleaved push/pop with IDs 0..9 -> pops return IDs 0..9 in order, q_count never exceeds DEPTH.
REQ-029 Reset mid-stream: 3 entries queued, assert reset one cycle with r2b_req=1 -> q_count=0, q_valid=0, open_valid cleared, nothing stored.
REQ-030 Split request: two chunks, r2b_start=1/last=0 then start=0/last=1, same id -> both dequeued in order with flags intact.

Source files
------------

// File: rtl/sdrc_req_queue.sv
// sdrc_req_queue
// Request queue between the SDRAM request generator and the bank/command
// logic. Chunk requests are buffered in a strict-FIFO circular store and
// the head entry is presented combinationally to the consumer. A small
// open-row table tracks which row each bank last activated, so the head
// can be flagged as a row hit.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   r2b_*               incoming chunk request and its fields
//   b2r_ack             chunk accepted this cycle (combinational)
//   b2r_arb_ok          room for a whole new application request (two chunks)
//   q_valid, q_*        head entry and its fields
//   q_row_hit           head row is already open in its bank
//   q_pop               consumer takes the head entry
//   bank_close          per-bank precharge done, clears that bank's open row
//   q_count             occupancy, 0..DEPTH
module sdrc_req_queue #(
    parameter int APP_RW = 9,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       r2b_req,
    input  logic [ID_W-1:0]            r2b_req_id,
    input  logic                       r2b_start,
    input  logic                       r2b_last,
    input  logic                       r2b_wrap,
    input  logic                       r2b_write,
    input  logic [1:0]                 r2b_ba,
    input  logic [11:0]                r2b_raddr,
    input  logic [11:0]                r2b_caddr,
    input  logic [APP_RW-1:0]          r2b_len,
    output logic                       b2r_ack,
    output logic                       b2r_arb_ok,
    output logic                       q_valid,
    output logic [ID_W-1:0]            q_req_id,
    output logic                       q_start,
    output logic                       q_last,
    output logic                       q_wrap,
    output logic                       q_write,
    output logic [1:0]                 q_ba,
    output logic [11:0]                q_raddr,
    output logic [11:0]                q_caddr,
    output logic [APP_RW-1:0]          q_len,
    output logic                       q_row_hit,
    input  logic                       q_pop,
    input  logic [3:0]                 bank_close,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    // Leave room for two chunks so a page-split request always fits.
    localparam logic [CW-1:0] ARB_MAX  = CW'(DEPTH - 2);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic              start;
        logic              last;
        logic              wrap;
        logic              write;
        logic [1:0]        ba;
        logic [11:0]       raddr;
        logic [11:0]       caddr;
        logic [APP_RW-1:0] len;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          wr_entry;
    entry_t          head;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push;
    logic            pop;
    logic [3:0]      open_valid_q;
    logic [11:0]     open_row_q [4];

    // ---------------------------------------------------------------
    // FIFO control
    // ---------------------------------------------------------------
    // Full blocks a push even when a pop happens in the same cycle.
    assign b2r_ack    = r2b_req & (count_q != FULL_CNT);
    assign b2r_arb_ok = (count_q <= ARB_MAX);
    assign q_valid    = (count_q != '0);
    assign push       = b2r_ack;
    assign pop        = q_pop & q_valid;
    assign q_count    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so the pointers wrap by overflow.
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ---------------------------------------------------------------
    // Storage (not reset; a request arriving during reset is dropped)
    // ---------------------------------------------------------------
    assign wr_entry = '{id: r2b_req_id, start: r2b_start, last: r2b_last,
                        wrap: r2b_wrap, write: r2b_write, ba: r2b_ba,
                        raddr: r2b_raddr, caddr: r2b_caddr, len: r2b_len};

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Head read is combinational so a push shows up only after the edge.
    assign head     = mem_q[rd_ptr_q];
    assign q_req_id = head.id;
    assign q_start  = head.start;
    assign q_last   = head.last;
    assign q_wrap   = head.wrap;
    assign q_write  = head.write;
    assign q_ba     = head.ba;
    assign q_raddr  = head.raddr;
    assign q_caddr  = head.caddr;
    assign q_len    = head.len;

    // ---------------------------------------------------------------
    // Open-row table, one slot per bank
    // ---------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank
            logic pop_hit;
            logic valid_d;

            assign pop_hit = pop && (head.ba == 2'(gi));

            // A pop to this bank wins over a simultaneous precharge.
            always_comb begin
                valid_d = open_valid_q[gi];
                if (pop_hit)            valid_d = 1'b1;
                else if (bank_close[gi]) valid_d = 1'b0;
            end

            always_ff @(posedge clk) begin
                if (reset) open_valid_q[gi] <= 1'b0;
                else       open_valid_q[gi] <= valid_d;
            end

            always_ff @(posedge clk) begin
                if (pop_hit && !reset) open_row_q[gi] <= head.raddr;
            end
        end
    endgenerate

    assign q_row_hit = q_valid & open_valid_q[head.ba] &
                       (open_row_q[head.ba] == head.raddr);

endmodule

// File: tb/tb_sdrc_req_queue.sv
module tb_sdrc_req_queue;

    localparam int APP_RW = 9;
    localparam int ID_W   = 4;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              r2b_req;
    logic [ID_W-1:0]   r2b_req_id;
    logic              r2b_start, r2b_last, r2b_wrap, r2b_write;
    logic [1:0]        r2b_ba;
    logic [11:0]       r2b_raddr, r2b_caddr;
    logic [APP_RW-1:0] r2b_len;
    logic              b2r_ack, b2r_arb_ok, q_valid;
    logic [ID_W-1:0]   q_req_id;
    logic              q_start, q_last, q_wrap, q_write;
    logic [1:0]        q_ba;
    logic [11:0]       q_raddr, q_caddr;
    logic [APP_RW-1:0] q_len;
    logic              q_row_hit;
    logic              q_pop;
    logic [3:0]        bank_close;
    logic [2:0]        q_count;

    always #5 clk = ~clk;

    sdrc_req_queue #(.APP_RW(APP_RW), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .r2b_req(r2b_req), .r2b_req_id(r2b_req_id), .r2b_start(r2b_start),
        .r2b_last(r2b_last), .r2b_wrap(r2b_wrap), .r2b_write(r2b_write),
        .r2b_ba(r2b_ba), .r2b_raddr(r2b_raddr), .r2b_caddr(r2b_caddr),
        .r2b_len(r2b_len), .b2r_ack(b2r_ack), .b2r_arb_ok(b2r_arb_ok),
        .q_valid(q_valid), .q_req_id(q_req_id), .q_start(q_start),
        .q_last(q_last), .q_wrap(q_wrap), .q_write(q_write), .q_ba(q_ba),
        .q_raddr(q_raddr), .q_caddr(q_caddr), .q_len(q_len),
        .q_row_hit(q_row_hit), .q_pop(q_pop), .bank_close(bank_close),
        .q_count(q_count)
    );

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic              start;
        logic              last;
        logic              wrap;
        logic              write;
        logic [1:0]        ba;
        logic [11:0]       raddr;
        logic [11:0]       caddr;
        logic [APP_RW-1:0] len;
    } ent_t;

    ent_t sb [$];
    ent_t head_obs;
    ent_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   m_count = 0;
    logic exp_ack = 1'b0;
    logic exp_pop = 1'b0;
    logic chk_en  = 1'b0;

    assign head_obs = {q_req_id, q_start, q_last, q_wrap, q_write, q_ba,
                       q_raddr, q_caddr, q_len};

    // Scoreboard side: compares ack, occupancy and each popped head
    // against the model, midway between active edges.
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (b2r_ack !== exp_ack) begin
                bad++;
                $display("FAIL ack: got %b want %b", b2r_ack, exp_ack);
            end
            total++;
            if (q_count !== 3'(m_count)) begin
                bad++;
                $display("FAIL count: got %0d want %0d", q_count, m_count);
            end
            if (exp_pop) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL pop_underflow: got head id %0d want no entry", q_req_id);
                end else begin
                    mon_e = sb.pop_front();
                    if (head_obs !== mon_e) begin
                        bad++;
                        $display("FAIL pop_data: got id=%0d ba=%0d row=%h col=%h len=%0d s=%b l=%b want id=%0d ba=%0d row=%h col=%h len=%0d s=%b l=%b",
                                 q_req_id, q_ba, q_raddr, q_caddr, q_len, q_start, q_last,
                                 mon_e.id, mon_e.ba, mon_e.raddr, mon_e.caddr, mon_e.len,
                                 mon_e.start, mon_e.last);
                    end else begin
                        $display("pop id=%0d ba=%0d row=%h ok", q_req_id, q_ba, q_raddr);
                    end
                end
            end
        end
    end

    function automatic ent_t mk(input int id, input int ba, input int row,
                                input int col, input int len,
                                input logic st, input logic la);
        ent_t e;
        e.id = ID_W'(id);   e.start = st;  e.last = la;
        e.wrap = 1'(id);    e.write = 1'(id >> 1);
        e.ba = 2'(ba);      e.raddr = 12'(row);
        e.caddr = 12'(col); e.len = APP_RW'(len);
        return e;
    endfunction

    // One clock of stimulus; the model decides what the DUT must accept.
    task automatic drive(input logic push, input ent_t e, input logic pop,
                         input logic [3:0] bc, input logic rst);
        reset = rst; r2b_req = push; q_pop = pop; bank_close = bc;
        {r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write, r2b_ba,
         r2b_raddr, r2b_caddr, r2b_len} = e;
        exp_ack = push && (m_count != DEPTH);
        exp_pop = pop && (m_count != 0) && !rst;
        if (exp_ack && !rst) sb.push_back(e);
        if (push) $display("push id=%0d ba=%0d row=%h expect_ack=%b", e.id, e.ba, e.raddr, exp_ack);
        @(posedge clk); #1;
        if (rst) begin
            m_count = 0;
            sb.delete();
        end else begin
            m_count = m_count + int'(exp_ack && !rst) - int'(exp_pop);
        end
        reset = 1'b0; r2b_req = 1'b0; q_pop = 1'b0; bank_close = 4'b0;
        exp_ack = 1'b0; exp_pop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; r2b_req = 1'b1; q_pop = 1'b0; bank_close = 4'b0;
        {r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write, r2b_ba,
         r2b_raddr, r2b_caddr, r2b_len} = '0;
        @(posedge clk); #1; @(posedge clk); #1;
        total++; if (q_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", q_count); end
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", q_valid); end
        total++; if (q_row_hit !== 1'b0) begin bad++; $display("FAIL rst_row_hit: got %b want 0", q_row_hit); end
        total++; if (b2r_arb_ok !== 1'b1) begin bad++; $display("FAIL rst_arb_ok: got %b want 1", b2r_arb_ok); end
        total++; if (b2r_ack !== 1'b1) begin bad++; $display("FAIL rst_ack: got %b want 1", b2r_ack); end
        reset = 1'b0; r2b_req = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
    endtask

    task automatic test_single_push();
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL sp_pre_valid: got %b want 0", q_valid); end
        drive(1, mk(3, 2, 'h055, 'h0F0, 8, 1, 1), 0, 4'b0, 0);
        total++; if (q_valid !== 1'b1) begin bad++; $display("FAIL sp_valid: got %b want 1", q_valid); end
        total++; if ({q_req_id, q_ba, q_raddr, q_caddr, q_len} !== {4'd3, 2'd2, 12'h055, 12'h0F0, 9'd8}) begin
            bad++; $display("FAIL sp_fields: got id=%0d ba=%0d row=%h col=%h len=%0d want id=3 ba=2 row=055 col=0f0 len=8",
                            q_req_id, q_ba, q_raddr, q_caddr, q_len);
        end
        total++; if (q_row_hit !== 1'b0) begin bad++; $display("FAIL sp_row_hit: got %b want 0", q_row_hit); end
        total++; if (q_count !== 3'd1) begin bad++; $display("FAIL sp_count: got %0d want 1", q_count); end
        drive(0, '0, 1, 4'b0, 0);
    endtask

    task automatic test_pop_empty();
        drive(0, '0, 1, 4'b0, 0);
        total++; if (q_count !== 3'd0 || q_valid !== 1'b0) begin
            bad++; $display("FAIL pop_empty: got count=%0d valid=%b want 0/0", q_count, q_valid);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, mk(4 + i, 0, 'h200 + i, 'h010 * i, 4 + i, 1, 1), 0, 4'b0, 0);
            total++;
            if (b2r_arb_ok !== (m_count <= DEPTH - 2)) begin
                bad++; $display("FAIL fill_arb_ok: count=%0d got %b want %b", m_count, b2r_arb_ok, (m_count <= DEPTH - 2));
            end
        end
        // Push while full with no pop: rejected, occupancy held.
        drive(1, mk(14, 3, 'hEEE, 'hEEE, 1, 0, 0), 0, 4'b0, 0);
        total++; if (q_count !== 3'd4) begin bad++; $display("FAIL full_hold: got %0d want 4", q_count); end
        // Push with pop while full: push still rejected; the drain below
        // proves the rejected data never entered the queue.
        drive(1, mk(15, 3, 'hFFF, 'hFFF, 2, 0, 0), 1, 4'b0, 0);
        total++; if (q_count !== 3'd3) begin bad++; $display("FAIL full_pushpop: got %0d want 3", q_count); end
        for (int i = 0; i < 3; i++) drive(0, '0, 1, 4'b0, 0);
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL fill_drain: got valid %b want 0", q_valid); end
    endtask

    task automatic test_row_tracking();
        for (int i = 1; i <= 3; i++) drive(1, mk(i, 1, 'h100, 'h020 * i, 16, 0, 0), 0, 4'b0, 0);
        drive(0, '0, 1, 4'b0, 0);
        total++; if (q_row_hit !== 1'b1) begin bad++; $display("FAIL row_hit_open: got %b want 1", q_row_hit); end
        drive(0, '0, 0, 4'b0010, 0);
        total++; if (q_row_hit !== 1'b0) begin bad++; $display("FAIL row_closed: got %b want 0", q_row_hit); end
        drive(0, '0, 1, 4'b0010, 0);
        total++; if (q_row_hit !== 1'b1) begin bad++; $display("FAIL row_pop_wins: got %b want 1", q_row_hit); end
        drive(0, '0, 0, 4'b0001, 0);
        total++; if (q_row_hit !== 1'b1) begin bad++; $display("FAIL row_other_bank: got %b want 1", q_row_hit); end
        drive(1, mk(4, 1, 'h101, 'h000, 16, 0, 0), 0, 4'b0, 0);
        drive(0, '0, 1, 4'b0, 0);
        total++; if (q_row_hit !== 1'b0) begin bad++; $display("FAIL row_diff: got %b want 0", q_row_hit); end
        drive(0, '0, 1, 4'b0, 0);
    endtask

    task automatic test_wrap();
        drive(1, mk(0, 0, 'h300, 'h000, 1, 1, 1), 0, 4'b0, 0);
        for (int i = 1; i < 10; i++) begin
            drive(1, mk(i, i % 4, 'h300 + i, 'h004 * i, i + 1, 1, 1), 1, 4'b0, 0);
            total++;
            if (q_count !== 3'd1) begin bad++; $display("FAIL wrap_count: iter %0d got %0d want 1", i, q_count); end
        end
        drive(0, '0, 1, 4'b0, 0);
        total++; if (q_count !== 3'd0 || sb.size() != 0) begin
            bad++; $display("FAIL wrap_end: got count=%0d pending=%0d want 0/0", q_count, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        drive(1, mk(1, 3, 'h02A, 'h001, 3, 0, 0), 0, 4'b0, 0);
        drive(1, mk(2, 3, 'h02A, 'h002, 3, 0, 0), 0, 4'b0, 0);
        drive(0, '0, 1, 4'b0, 0);
        total++; if (q_row_hit !== 1'b1) begin bad++; $display("FAIL rm_pre_hit: got %b want 1", q_row_hit); end
        drive(1, mk(3, 0, 'h011, 'h003, 3, 0, 0), 0, 4'b0, 0);
        drive(1, mk(4, 0, 'h012, 'h004, 3, 0, 0), 0, 4'b0, 0);
        drive(1, mk(9, 2, 'h0AA, 'h0BB, 7, 1, 1), 0, 4'b0, 1);
        total++; if (q_count !== 3'd0 || q_valid !== 1'b0) begin
            bad++; $display("FAIL rm_cleared: got count=%0d valid=%b want 0/0", q_count, q_valid);
        end
        total++; if (b2r_arb_ok !== 1'b1 || q_row_hit !== 1'b0) begin
            bad++; $display("FAIL rm_flags: got arb_ok=%b row_hit=%b want 1/0", b2r_arb_ok, q_row_hit);
        end
        drive(1, mk(5, 3, 'h02A, 'h005, 3, 0, 0), 0, 4'b0, 0);
        total++; if (q_row_hit !== 1'b0) begin bad++; $display("FAIL rm_open_valid: got %b want 0", q_row_hit); end
        total++; if (q_req_id !== 4'd5 || q_count !== 3'd1) begin
            bad++; $display("FAIL rm_nothing_stored: got id=%0d count=%0d want 5/1", q_req_id, q_count);
        end
        drive(0, '0, 1, 4'b0, 0);
    endtask

    task automatic test_split();
        drive(1, mk(6, 1, 'h0C0, 'h3F8, 8, 1, 0), 0, 4'b0, 0);
        drive(1, mk(6, 1, 'h0C1, 'h000, 8, 0, 1), 0, 4'b0, 0);
        total++; if (q_count !== 3'd2 || q_start !== 1'b1 || q_last !== 1'b0) begin
            bad++; $display("FAIL split_first: got count=%0d start=%b last=%b want 2/1/0", q_count, q_start, q_last);
        end
        drive(0, '0, 1, 4'b0, 0);
        total++; if (q_req_id !== 4'd6 || q_start !== 1'b0 || q_last !== 1'b1) begin
            bad++; $display("FAIL split_second: got id=%0d start=%b last=%b want 6/0/1", q_req_id, q_start, q_last);
        end
        drive(0, '0, 1, 4'b0, 0);
        total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL split_empty: got %b want 0", q_valid); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_pop_empty();
        test_fill();
        test_row_tracking();
        test_wrap();
        test_reset_mid();
        test_split();
        @(posedge clk); #1;
        chk_en = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
